// File: rtl/alu_share_if.sv
// Bundles the two requester ports, the shared-ALU drive/return path and Busy for alu_share_arbiter.
// The arbiter connects through the slave modport; requesters and the ALU model sit on the master side.
interface alu_share_if;
    localparam int unsigned DataW = 32;
    localparam int unsigned FunW  = 5;
    localparam int unsigned FlagW = 4;

    logic             req0_valid;
    logic             req0_ready;
    logic [FunW-1:0]  req0_fun_sel;
    logic [DataW-1:0] req0_a;
    logic [DataW-1:0] req0_b;
    logic             req0_wf;
    logic             req0_lock;

    logic             req1_valid;
    logic             req1_ready;
    logic [FunW-1:0]  req1_fun_sel;
    logic [DataW-1:0] req1_a;
    logic [DataW-1:0] req1_b;
    logic             req1_wf;
    logic             req1_lock;

    logic             rsp0_valid;
    logic             rsp1_valid;
    logic [DataW-1:0] rsp_data;
    logic [FlagW-1:0] rsp_flags;

    logic [DataW-1:0] alu_a;
    logic [DataW-1:0] alu_b;
    logic [FunW-1:0]  alu_fun_sel;
    logic             alu_wf;
    logic [DataW-1:0] alu_out;
    logic [FlagW-1:0] alu_flags;

    logic             busy;

    modport slave (
        input  req0_valid, req0_fun_sel, req0_a, req0_b, req0_wf, req0_lock,
        input  req1_valid, req1_fun_sel, req1_a, req1_b, req1_wf, req1_lock,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_flags,
        output alu_a, alu_b, alu_fun_sel, alu_wf,
        input  alu_out, alu_flags,
        output busy
    );

    modport master (
        output req0_valid, req0_fun_sel, req0_a, req0_b, req0_wf, req0_lock,
        output req1_valid, req1_fun_sel, req1_a, req1_b, req1_wf, req1_lock,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_flags,
        input  alu_a, alu_b, alu_fun_sel, alu_wf,
        output alu_out, alu_flags,
        input  busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one registered ALU between two requesters: accept, wait ALU_LATENCY, respond.
// Optional requester lock for multi-operation carry chains is enabled with `define ALU_SHARE_LOCK_EN.
module alu_share_arbiter #(
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned LOCK_MAX    = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    alu_share_if.slave bus
);
    localparam int unsigned DataW = 32;
    localparam int unsigned FunW  = 5;
    localparam int unsigned FlagW = 4;
    localparam int unsigned CntW  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e           state_q,       state_d;
    logic             last_grant_q,  last_grant_d;
    logic             owner_q,       owner_d;
    logic [CntW-1:0]  cnt_q,         cnt_d;
    logic [DataW-1:0] alu_a_q,       alu_a_d;
    logic [DataW-1:0] alu_b_q,       alu_b_d;
    logic [FunW-1:0]  alu_fun_sel_q, alu_fun_sel_d;
    logic             alu_wf_q,      alu_wf_d;
    logic [DataW-1:0] rsp_data_q,    rsp_data_d;
    logic [FlagW-1:0] rsp_flags_q,   rsp_flags_d;
    logic             rsp0_valid_q,  rsp0_valid_d;
    logic             rsp1_valid_q,  rsp1_valid_d;
    logic             busy_q,        busy_d;

    logic elig0_c;
    logic elig1_c;
    logic ready0_c;
    logic ready1_c;
    logic accept_c;
    logic sel_c;

`ifdef ALU_SHARE_LOCK_EN
    localparam int unsigned LockCntW = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);

    logic                lock_q,       lock_d;
    logic                lock_owner_q, lock_owner_d;
    logic                op_lock_q,    op_lock_d;
    logic [LockCntW-1:0] lock_cnt_q,   lock_cnt_d;

    // A held lock masks the non-owner out of arbitration entirely.
    assign elig0_c = bus.req0_valid && (!lock_q || !lock_owner_q);
    assign elig1_c = bus.req1_valid && (!lock_q ||  lock_owner_q);
`else
    logic unused_lock_c;

    assign elig0_c       = bus.req0_valid;
    assign elig1_c       = bus.req1_valid;
    assign unused_lock_c = ^{bus.req0_lock, bus.req1_lock, 32'(LOCK_MAX)};
`endif

    // Ties go to the requester not granted last; ready is forced low while reset is asserted.
    assign ready0_c = rst_ni && (state_q == ST_IDLE) && elig0_c && (!elig1_c || last_grant_q);
    assign ready1_c = rst_ni && (state_q == ST_IDLE) && elig1_c && (!elig0_c || !last_grant_q);
    assign accept_c = ready0_c || ready1_c;
    assign sel_c    = ready1_c;

    // Next-state and datapath updates.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_fun_sel_d = alu_fun_sel_q;
        alu_wf_d      = alu_wf_q;
        rsp_data_d    = rsp_data_q;
        rsp_flags_d   = rsp_flags_q;
        rsp0_valid_d  = 1'b0;
        rsp1_valid_d  = 1'b0;
`ifdef ALU_SHARE_LOCK_EN
        lock_d        = lock_q;
        lock_owner_d  = lock_owner_q;
        op_lock_d     = op_lock_q;
        lock_cnt_d    = lock_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    alu_a_d       = sel_c ? bus.req1_a       : bus.req0_a;
                    alu_b_d       = sel_c ? bus.req1_b       : bus.req0_b;
                    alu_fun_sel_d = sel_c ? bus.req1_fun_sel : bus.req0_fun_sel;
                    alu_wf_d      = sel_c ? bus.req1_wf      : bus.req0_wf;
                    owner_d       = sel_c;
                    last_grant_d  = sel_c;
                    cnt_d         = CntW'(ALU_LATENCY);
                    state_d       = ST_WAIT;
`ifdef ALU_SHARE_LOCK_EN
                    op_lock_d     = sel_c ? bus.req1_lock : bus.req0_lock;
                    if (op_lock_d) begin
                        lock_d       = 1'b1;
                        lock_owner_d = sel_c;
                    end
`endif
                end
            end

            ST_WAIT: begin
                if (cnt_q == CntW'(0)) begin
                    rsp_data_d   = bus.alu_out;
                    rsp_flags_d  = bus.alu_flags;
                    alu_wf_d     = 1'b0;
                    rsp0_valid_d = !owner_q;
                    rsp1_valid_d = owner_q;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
`ifdef ALU_SHARE_LOCK_EN
                // Release on an unlocked completion by the owner, or when the locked run hits its limit.
                if (lock_q && (lock_owner_q == owner_q)) begin
                    if (!op_lock_q || ((32'(lock_cnt_q) + 32'd1) >= LOCK_MAX)) begin
                        lock_d     = 1'b0;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LockCntW'(1);
                    end
                end
`endif
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Busy reflects the state and lock being entered.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
`ifdef ALU_SHARE_LOCK_EN
        busy_d = busy_d || lock_d;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            cnt_q         <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_fun_sel_q <= '0;
            alu_wf_q      <= 1'b0;
            rsp_data_q    <= '0;
            rsp_flags_q   <= '0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
`ifdef ALU_SHARE_LOCK_EN
            lock_q        <= 1'b0;
            lock_owner_q  <= 1'b0;
            op_lock_q     <= 1'b0;
            lock_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_fun_sel_q <= alu_fun_sel_d;
            alu_wf_q      <= alu_wf_d;
            rsp_data_q    <= rsp_data_d;
            rsp_flags_q   <= rsp_flags_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp1_valid_q  <= rsp1_valid_d;
            busy_q        <= busy_d;
`ifdef ALU_SHARE_LOCK_EN
            lock_q        <= lock_d;
            lock_owner_q  <= lock_owner_d;
            op_lock_q     <= op_lock_d;
            lock_cnt_q    <= lock_cnt_d;
`endif
        end
    end

    assign bus.req0_ready  = ready0_c;
    assign bus.req1_ready  = ready1_c;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_fun_sel = alu_fun_sel_q;
    assign bus.alu_wf      = alu_wf_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_flags   = rsp_flags_q;
    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a latency-1 instance (LOCK_MAX=4) and a latency-3 instance.
// Lock scenarios run only when ALU_SHARE_LOCK_EN is defined.
module tb_alu_share_arbiter;
    localparam logic [4:0] ADD = 5'b10100;
    localparam logic [4:0] ADC = 5'b10101;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests  = 0;
    int   fails  = 0;
    int   both_hi = 0;

    always #5 clk = ~clk;

    alu_share_if ia ();
    alu_share_if ib ();

    alu_share_arbiter #(.ALU_LATENCY(1), .LOCK_MAX(4)) dut_a (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (ia)
    );

    alu_share_arbiter #(.ALU_LATENCY(3)) dut_b (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (ib)
    );

    // Reference ALU: result in [31:0], flags {Z,C,N,O} in [35:32].
    function automatic logic [35:0] alu_f(input logic [4:0] fs, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
        logic [32:0] s;
        logic        o;
        s = '0;
        o = 1'b0;
        case (fs)
            ADD:     s = {1'b0, a} + {1'b0, b};
            ADC:     s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            default: s = {1'b0, a & b};
        endcase
        if (fs == ADD || fs == ADC) o = (a[31] == b[31]) && (s[31] != a[31]);
        return {(s[31:0] == 32'd0), s[32], s[31], o, s[31:0]};
    endfunction

    // Latency-1 ALU with a carry flag register written under WF.
    logic [31:0] a_res = '0;
    logic [3:0]  a_flg = '0;
    always @(posedge clk) begin
        logic [35:0] r;
        r = alu_f(ia.alu_fun_sel, ia.alu_a, ia.alu_b, a_flg[2]);
        a_res <= r[31:0];
        if (ia.alu_wf) a_flg <= r[35:32];
    end
    assign ia.alu_out   = a_res;
    assign ia.alu_flags = a_flg;

    // Three-stage ALU pipeline for the latency-3 instance.
    logic [35:0] b_s0 = '0;
    logic [35:0] b_s1 = '0;
    logic [35:0] b_s2 = '0;
    always @(posedge clk) begin
        b_s0 <= alu_f(ib.alu_fun_sel, ib.alu_a, ib.alu_b, 1'b0);
        b_s1 <= b_s0;
        b_s2 <= b_s1;
    end
    assign ib.alu_out   = b_s2[31:0];
    assign ib.alu_flags = b_s2[35:32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ia.req0_ready && ia.req1_ready) both_hi++;
    endtask

    // Leaves the bench just before the accept edge; who = -1 on timeout.
    task automatic wait_grant(output int who);
        who = -1;
        for (int c = 0; c < 20 && who < 0; c++) begin
            #1;
            if (ia.req0_ready && ia.req1_ready) both_hi++;
            if (ia.req0_ready)      who = 0;
            else if (ia.req1_ready) who = 1;
            else                    tick();
        end
        chk("grant_seen", 64'(who >= 0), 64'd1);
    endtask

    // Called after the accept edge; ends in the following IDLE cycle.
    task automatic wait_rsp(input int who, input logic [31:0] ed, input logic [3:0] ef,
                            input bit cf, input int el);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            lat++;
            if (ia.rsp0_valid || ia.rsp1_valid) seen = 1'b1;
        end
        chk("rsp_seen", 64'(seen), 64'd1);
        chk("rsp_latency", 64'(lat), 64'(el));
        chk("rsp0_tag", 64'(ia.rsp0_valid), 64'(who == 0));
        chk("rsp1_tag", 64'(ia.rsp1_valid), 64'(who == 1));
        chk("rsp_data", 64'(ia.rsp_data), 64'(ed));
        if (cf) chk("rsp_flags", 64'(ia.rsp_flags), 64'(ef));
        chk("wf_in_resp", 64'(ia.alu_wf), 64'd0);
        chk("ready_in_resp", 64'(ia.req0_ready | ia.req1_ready), 64'd0);
        tick();
        chk("rsp_pulse_end", 64'(ia.rsp0_valid | ia.rsp1_valid), 64'd0);
    endtask

    initial begin
        int who;
        int pulses;

        {ia.req0_valid, ia.req0_fun_sel, ia.req0_a, ia.req0_b, ia.req0_wf, ia.req0_lock} = '0;
        {ia.req1_valid, ia.req1_fun_sel, ia.req1_a, ia.req1_b, ia.req1_wf, ia.req1_lock} = '0;
        {ib.req0_valid, ib.req0_fun_sel, ib.req0_a, ib.req0_b, ib.req0_wf, ib.req0_lock} = '0;
        {ib.req1_valid, ib.req1_fun_sel, ib.req1_a, ib.req1_b, ib.req1_wf, ib.req1_lock} = '0;

        // Reset state, with requests pending during reset.
        ia.req0_valid = 1'b1;
        ia.req1_valid = 1'b1;
        tick();
        tick();
        chk("reset_ready0", 64'(ia.req0_ready), 64'd0);
        chk("reset_ready1", 64'(ia.req1_ready), 64'd0);
        chk("reset_busy", 64'(ia.busy), 64'd0);
        chk("reset_alu_a", 64'(ia.alu_a), 64'd0);
        chk("reset_rsp", 64'({ia.rsp_data, ia.rsp_flags, ia.rsp0_valid, ia.rsp1_valid}), 64'd0);
        ia.req0_valid = 1'b0;
        ia.req1_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Requester 0 alone: 5 + 7.
        ia.req0_fun_sel = ADD;
        ia.req0_a = 32'd5;
        ia.req0_b = 32'd7;
        ia.req0_wf = 1'b1;
        ia.req0_valid = 1'b1;
        #1;
        chk("t1_ready0", 64'(ia.req0_ready), 64'd1);
        chk("t1_ready1", 64'(ia.req1_ready), 64'd0);
        tick();
        ia.req0_valid = 1'b0;
        chk("t1_ready0_wait", 64'(ia.req0_ready), 64'd0);
        chk("t1_alu_ab", 64'({ia.alu_a, ia.alu_b}), {32'd5, 32'd7});
        chk("t1_alu_fs", 64'(ia.alu_fun_sel), 64'(ADD));
        chk("t1_alu_wf", 64'(ia.alu_wf), 64'd1);
        chk("t1_busy", 64'(ia.busy), 64'd1);
        wait_rsp(0, 32'h0000000C, 4'b0000, 1'b1, 2);
        chk("t1_hold_data", 64'(ia.rsp_data), 64'hC);
        chk("t1_idle_busy", 64'(ia.busy), 64'd0);
        chk("t1_hold_alu_a", 64'(ia.alu_a), 64'd5);

        // Both requesters valid from reset: grants alternate 0,1,0,1.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ia.req0_a = 32'd100;
        ia.req0_b = 32'd1;
        ia.req1_fun_sel = ADD;
        ia.req1_a = 32'd200;
        ia.req1_b = 32'd2;
        ia.req1_wf = 1'b1;
        ia.req0_valid = 1'b1;
        ia.req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(who);
            chk("rr_grant", 64'(who), 64'(k % 2));
            tick();
            wait_rsp(who, (who == 1) ? 32'd202 : 32'd101, 4'b0000, 1'b0, 2);
        end
        chk("ready_exclusive", 64'(both_hi), 64'd0);

        // Reset during WAIT discards the operation and restores LastGrant.
        ia.req1_valid = 1'b0;
        ia.req0_a = 32'h55;
        ia.req0_b = 32'h11;
        wait_grant(who);
        chk("rst_pre_grant", 64'(who), 64'd0);
        tick();
        ia.req0_valid = 1'b0;
        ia.req1_fun_sel = ADD;
        ia.req1_a = 32'd7;
        ia.req1_b = 32'd8;
        chk("rst_pre_alu_a", 64'(ia.alu_a), 64'h55);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_alu_outs", 64'({ia.alu_a, ia.alu_b}), 64'd0);
        chk("rst_alu_ctl", 64'({ia.alu_fun_sel, ia.alu_wf}), 64'd0);
        chk("rst_busy", 64'(ia.busy), 64'd0);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            if (ia.rsp0_valid || ia.rsp1_valid) pulses++;
            tick();
        end
        chk("rst_no_pulse", 64'(pulses), 64'd0);
        ia.req0_valid = 1'b1;
        ia.req1_valid = 1'b1;
        #1;
        chk("rst_tie_ready0", 64'(ia.req0_ready), 64'd1);
        chk("rst_tie_ready1", 64'(ia.req1_ready), 64'd0);
        tick();
        ia.req0_valid = 1'b0;
        wait_rsp(0, 32'h66, 4'b0000, 1'b0, 2);
        wait_grant(who);
        chk("rst_next_grant", 64'(who), 64'd1);
        tick();
        ia.req1_valid = 1'b0;
        wait_rsp(1, 32'd15, 4'b0000, 1'b0, 2);

        // Latency-3 instance: operand hold, capture timing and next accept.
        ib.req0_fun_sel = ADD;
        ib.req0_a = 32'd10;
        ib.req0_b = 32'd20;
        ib.req0_wf = 1'b1;
        ib.req0_valid = 1'b1;
        #1;
        chk("l3_ready0", 64'(ib.req0_ready), 64'd1);
        tick();
        ib.req0_a = 32'd3;
        ib.req0_b = 32'd4;
        for (int c = 0; c < 4; c++) tick();
        chk("l3_op1_rsp", 64'({ib.rsp0_valid, ib.rsp_data}), {31'd0, 1'b1, 32'd30});
        chk("l3_resp_ready", 64'(ib.req0_ready), 64'd0);
        tick();
        chk("l3_idle_ready", 64'(ib.req0_ready), 64'd1);
        tick();
        chk("l3_op2_alu_a", 64'(ib.alu_a), 64'd3);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("l3_wait_no_rsp", 64'(ib.rsp0_valid | ib.rsp1_valid), 64'd0);
            chk("l3_wait_hold", 64'({ib.alu_a, ib.alu_b}), {32'd3, 32'd4});
            chk("l3_wait_wf", 64'(ib.alu_wf), 64'd1);
        end
        tick();
        chk("l3_op2_rsp", 64'({ib.rsp0_valid, ib.rsp_data}), {31'd0, 1'b1, 32'd7});
        chk("l3_capture_hold", 64'(ib.alu_a), 64'd3);
        chk("l3_no_early_accept", 64'(ib.req0_ready), 64'd0);
        ib.req0_valid = 1'b0;
        tick();
        chk("l3_pulse_end", 64'(ib.rsp0_valid), 64'd0);
        chk("l3_idle_busy", 64'(ib.busy), 64'd0);

`ifdef ALU_SHARE_LOCK_EN
        // 64-bit add: locked ADD then ADC while requester 1 waits.
        ia.req0_fun_sel = ADD;
        ia.req0_a = 32'hFFFFFFFF;
        ia.req0_b = 32'd1;
        ia.req0_wf = 1'b1;
        ia.req0_lock = 1'b1;
        ia.req0_valid = 1'b1;
        wait_grant(who);
        chk("lk_add_grant", 64'(who), 64'd0);
        tick();
        ia.req0_fun_sel = ADC;
        ia.req0_a = 32'd0;
        ia.req0_b = 32'd0;
        ia.req0_lock = 1'b0;
        ia.req1_valid = 1'b1;
        wait_rsp(0, 32'd0, 4'b1100, 1'b1, 2);
        wait_grant(who);
        chk("lk_adc_grant", 64'(who), 64'd0);
        tick();
        ia.req0_valid = 1'b0;
        wait_rsp(0, 32'd1, 4'b0000, 1'b1, 2);
        wait_grant(who);
        chk("lk_req1_after", 64'(who), 64'd1);
        tick();

        // Lock held indefinitely is released after four locked operations.
        ia.req0_fun_sel = ADD;
        ia.req0_a = 32'd1;
        ia.req0_b = 32'd1;
        ia.req0_lock = 1'b1;
        ia.req0_valid = 1'b1;
        wait_rsp(1, 32'd15, 4'b0000, 1'b0, 2);
        for (int k = 0; k < 4; k++) begin
            wait_grant(who);
            chk("lkmax_owner_grant", 64'(who), 64'd0);
            tick();
            wait_rsp(0, 32'd2, 4'b0000, 1'b0, 2);
            chk("lkmax_busy", 64'(ia.busy), 64'(k < 3));
        end
        wait_grant(who);
        chk("lkmax_release_grant", 64'(who), 64'd1);
        tick();
        ia.req0_valid = 1'b0;
        ia.req1_valid = 1'b0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer and arbiter that shares the single registered ArithmeticLogicUnit between two requesters, for example the instruction control unit and the address/stack calculation path. It accepts one operation at a time through a valid/ready handshake, drives the ALU's A, B, FunSel and WF inputs, waits the ALU pipeline latency, then returns ALUOut and FlagsOut to the requester that issued the operation. Arbitration is round-robin. An optional lock lets one requester hold the ALU across a multi-operation carry chain, such as a 64-bit add built from ADD followed by ADC.

## Interface
- ALU_LATENCY, default 1: number of edges between the ALU sampling its inputs and ALUOut/FlagsOut being valid; range 1 to 7.
- LOCK_MAX, default 8: maximum number of consecutive locked operations before the lock is forcibly released.
- Clock  in  1  single clock; all logic is on the posedge.
- Reset  in  1  synchronous, active-low.
- ReqNValid  in  1  operation request from requester N (N = 0, 1).
- ReqNReady  out  1  grant/accept to requester N; the handshake completes on a Clock edge where ReqNValid and ReqNReady are both 1.
- ReqNFunSel  in  5  ALU function select.
- ReqNA, ReqNB  in  32  ALU operands.
- ReqNWF  in  1  flag write enable.
- ReqNLock  in  1  hold the ALU for requester N after this operation.
- RspNValid  out  1  one-cycle pulse; RspData and RspFlags belong to requester N.
- RspData  out  32  captured ALUOut.
- RspFlags  out  4  captured FlagsOut, ordered Z, C, N, O.
- AluA, AluB  out  32  to ALU A and B.
- AluFunSel  out  5  to ALU FunSel.
- AluWF  out  1  to ALU WF.
- AluOut  in  32  from ALU ALUOut.
- AluFlags  in  4  from ALU FlagsOut.
- Busy  out  1  high in any state other than IDLE, or while a lock is held.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE**
  - ReqNReady is driven combinationally, and at most one ReqNReady is high in any cycle.
  - If only one requester is valid, grant it.
  - If both are valid, grant the requester that was not granted last. The LastGrant pointer resets to 1, so requester 0 wins the first tie.
  - On accept, register the operands into AluA, AluB and AluFunSel, and register the WF bit into AluWF. Record the owner, load cnt with ALU_LATENCY, and go to WAIT.
- **WAIT**
  - The Alu* outputs hold steady.
  - On each edge, if cnt is 0, capture AluOut into RspData and AluFlags into RspFlags, then go to RESP. Otherwise decrement cnt.
- **RESP**
  - RspNValid is high for exactly one cycle, for the owner only.
  - AluWF returns to 0.
  - On the next edge, go to IDLE. No request is accepted during RESP.
- RspData and RspFlags hold their last captured values until the next capture.
- Lock behaviour is described under Configuration.
- **Reset** (Reset low at an edge, in any state)
  - State becomes IDLE, LastGrant becomes 1, the lock is cleared and cnt becomes 0.
  - All outputs become 0: Alu*, RspData, RspFlags, RspNValid, ReqNReady and Busy.
  - An in-flight result is discarded and produces no RspNValid pulse.
- The block never modifies operands; width and carry semantics belong to the ALU.

## Timing
- A handshake at edge T:
  - AluA, AluB, AluFunSel and AluWF are valid from T through the end of the operation.
  - The ALU samples them at T+1.
  - Capture happens at edge T+1+ALU_LATENCY.
  - RspNValid is high between edges T+1+ALU_LATENCY and T+2+ALU_LATENCY.
  - The earliest next accept is at edge T+3+ALU_LATENCY.
- Throughput is one operation per ALU_LATENCY+3 cycles.
- ReqNReady is 0 in WAIT and in RESP.
- A requester must hold ReqN* stable while ReqNValid is high and not yet accepted.

## Configuration
- Macro: ALU_SHARE_LOCK_EN.
- **Defined**
  - Accepting an operation with ReqNLock=1 sets lock owner N.
  - While the lock is held, IDLE grants only the owner; the other requester stalls regardless of round-robin.
  - A locked counter counts completed locked operations.
  - The lock clears when the owner's operation with Lock=0 completes (in RESP), or when the locked counter reaches LOCK_MAX. After a LOCK_MAX release, the other requester has priority at the next IDLE if it is valid.
- **Undefined**
  - ReqNLock is ignored, there is no lock state, and arbitration is pure round-robin.
  - LOCK_MAX is unused.

## Test plan
- Requester 0 alone: FunSel=10100, A=5, B=7, ALU_LATENCY=1, handshake at T.
  - Required: Req0Ready is high only in the accept cycle.
  - Required: RspData=0x0000000C and a Rsp0Valid pulse after edge T+2; Rsp1Valid stays 0.
- Both requesters continuously valid from reset, 4 operations.
  - Required: grants in order 0, 1, 0, 1.
  - Required: each response tagged to the matching RspNValid, and the ReqNReady signals never both high.
- With ALU_SHARE_LOCK_EN: requester 0 issues ADD with Lock=1 (A=0xFFFFFFFF, B=1), then ADC with Lock=0, while Req1Valid is held high.
  - Required: Req1 is not granted until after the ADC response.
  - Required: first RspFlags C=1; ADC result captured as issued; requester 1 granted next.
- With ALU_SHARE_LOCK_EN and LOCK_MAX=4: requester 0 holds Lock=1 indefinitely while requester 1 is valid.
  - Required: requester 1 is granted immediately after the 4th locked response.
- Reset driven low for one edge while in WAIT.
  - Required: no RspNValid pulse, all Alu* outputs 0, Busy=0.
  - Required: the next simultaneous request is granted to requester 0.
- ALU_LATENCY=3, single operation accepted at T.
  - Required: Alu* stable through capture at edge T+4; Rsp pulse between edges T+4 and T+5; next accept no earlier than T+6.
